minimac_bufmem: RTL and testbench
=================================

MINIMAC_BUFMEM -- requirements
Module: minimac_bufmem

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h0000_0000: byte base address of the buffer window; bits [AW+1:0] are ignored.
REQ-002 SHALL have parameter AW, default 11: log2 of buffer depth in 32-bit words (default 2048 words, 8 KB).
REQ-003 SHALL have port sys_clk  input  1  single clock for all logic.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports wbrx_adr_i input 32, wbrx_cti_i input 3, wbrx_cyc_i input 1, wbrx_stb_i input 1, wbrx_dat_i input 32: RX write slave; WE=1 and SEL=1111 are implied.
REQ-006 SHALL have ports wbrx_ack_o output 1 and wbrx_err_o output 1: RX cycle termination.
REQ-007 SHALL have ports wbtx_adr_i input 32, wbtx_cti_i input 3, wbtx_cyc_i input 1, wbtx_stb_i input 1: TX read slave; WE=0 is implied.
REQ-008 SHALL have ports wbtx_ack_o output 1, wbtx_err_o output 1, wbtx_dat_o output 32: TX termination and read data.
REQ-009 SHALL have ports oor_o output 1 (sticky out-of-range flag) and oor_clr_i input 1 (clears oor_o).

Function
REQ-010 SHALL hold one single-port RAM of 2^AW x 32 bits, word index = adr[AW+1:2].
REQ-011 SHALL treat an access as in-window when adr[31:AW+2] == BASE_ADR[31:AW+2].
REQ-012 SHALL ignore *_cti_i; every access is a Wishbone classic single cycle.
REQ-013 SHALL use FSM states IDLE, GRANT_RX, GRANT_TX; IDLE -> GRANT_x when that port has cyc&stb; GRANT_x -> IDLE unconditionally after one cycle.
REQ-014 SHALL perform the RAM write (RX) or RAM read (TX) on the sys_clk edge that leaves IDLE into GRANT_x.
REQ-015 SHALL assert the granted port's ack_o (or err_o) for exactly one cycle, during GRANT_x: latency two cycles from stb sampled to ack visible, max throughput one access per two cycles.
REQ-016 SHALL present read data on wbtx_dat_o during wbtx_ack_o and hold it until the next TX read completes.
REQ-017 SHALL arbitrate round-robin when both ports request in IDLE: grant the port not served last; a lone requester is granted immediately regardless of history.
REQ-018 SHALL complete a granted access (RAM update and one-cycle ack) even if the master drops stb before ack.
REQ-019 SHALL never assert ack_o and err_o together, nor either on the non-granted port.
REQ-020 SHALL give RX-then-TX to the same word in consecutive grants the newly written data (no stale read).

Reset
REQ-021 SHALL on sys_rst: state IDLE, all ack_o/err_o 0, wbtx_dat_o 0, oor_o 0, last-served = TX (RX wins first tie).
REQ-022 SHALL on sys_rst asserted during GRANT_x drop the ack in the following cycle; RAM contents are not cleared.
REQ-023 SHALL give sys_rst priority over every other input, including oor_clr_i.

Configuration
REQ-024 SHALL with macro MINIMAC_BUFMEM_OOR_ERR_EN defined: an out-of-window access leaves RAM unmodified, terminates with err_o (not ack_o) one cycle after grant, returns 0 on wbtx_dat_o, and sets oor_o.
REQ-025 SHALL with MINIMAC_BUFMEM_OOR_ERR_EN undefined: no window check, addresses alias modulo 2^AW words, err_o tied 0, oor_o tied 0.
REQ-026 SHALL, with the macro defined, clear oor_o on oor_clr_i; a set event in the same cycle as oor_clr_i wins (oor_o stays 1).

Verification
REQ-027 SHALL cover: RX writes 32'hDEADBEEF to 32'h0000_0010, then TX reads 32'h0000_0010 -> wbrx_ack_o one pulse, wbtx_ack_o one pulse with wbtx_dat_o = 32'hDEADBEEF.
REQ-028 SHALL cover: RX and TX request simultaneously after reset -> RX acked first, TX acked two cycles later; repeat -> TX first.
REQ-029 SHALL cover: sys_rst pulsed in GRANT_TX -> wbtx_ack_o 0 next cycle, wbtx_dat_o 0, prior RAM data still readable afterwards.
REQ-030 SHALL cover: macro defined, BASE_ADR 32'h4000_0000, RX write to 32'h0000_0000 -> wbrx_err_o one pulse, oor_o 1, RAM unchanged; oor_clr_i -> oor_o 0.
REQ-031 SHALL cover: macro undefined, AW 11, write 32'h1234_5678 to 32'h0000_2004 -> TX read of 32'h0000_0004 returns 32'h1234_5678.
REQ-032 SHALL cover: 2048 back-to-back RX writes of address-as-data followed by 2048 TX reads -> every word matches, one ack per access, no ack on idle cycles.

Source files
------------

// File: rtl/minimac_bufmem.sv
// minimac_bufmem: shared 32-bit packet buffer with a Wishbone write slave (RX)
// and a Wishbone read slave (TX), round-robin arbitrated onto one
// single-port RAM. Every access takes two cycles: the grant edge and the ack cycle.
// Optional feature macro: MINIMAC_BUFMEM_OOR_ERR_EN. When it is defined, an
// access outside the BASE_ADR window ends with err instead of ack and sets
// the sticky oor_o flag.
module minimac_bufmem #(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int unsigned AW       = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] wbrx_adr_i,
    input  logic [2:0]  wbrx_cti_i,
    input  logic        wbrx_cyc_i,
    input  logic        wbrx_stb_i,
    input  logic [31:0] wbrx_dat_i,
    output logic        wbrx_ack_o,
    output logic        wbrx_err_o,
    input  logic [31:0] wbtx_adr_i,
    input  logic [2:0]  wbtx_cti_i,
    input  logic        wbtx_cyc_i,
    input  logic        wbtx_stb_i,
    output logic        wbtx_ack_o,
    output logic        wbtx_err_o,
    output logic [31:0] wbtx_dat_o,
    output logic        oor_o,
    input  logic        oor_clr_i
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, GRANT_RX, GRANT_TX} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_tx;
    logic            start_rx_c;
    logic            start_tx_c;
    logic            rx_req_c;
    logic            tx_req_c;
    logic            rx_in_c;
    logic            tx_in_c;
    logic [AW-1:0]   rx_idx_c;
    logic [AW-1:0]   tx_idx_c;
    logic [31:0]     mem [DEPTH];
    logic            unused_c;

    assign rx_req_c = wbrx_cyc_i & wbrx_stb_i;
    assign tx_req_c = wbtx_cyc_i & wbtx_stb_i;
    assign rx_idx_c = wbrx_adr_i[AW+1:2];
    assign tx_idx_c = wbtx_adr_i[AW+1:2];

`ifdef MINIMAC_BUFMEM_OOR_ERR_EN
    assign rx_in_c  = (wbrx_adr_i[31:AW+2] == BASE_ADR[31:AW+2]);
    assign tx_in_c  = (wbtx_adr_i[31:AW+2] == BASE_ADR[31:AW+2]);
    assign unused_c = ^{wbrx_adr_i[1:0], wbtx_adr_i[1:0], wbrx_cti_i, wbtx_cti_i,
                        BASE_ADR[AW+1:0]};

    // Sticky out-of-range flag; a new violation beats a same-cycle clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            oor_o <= 1'b0;
        end else if ((start_rx_c && !rx_in_c) || (start_tx_c && !tx_in_c)) begin
            oor_o <= 1'b1;
        end else if (oor_clr_i) begin
            oor_o <= 1'b0;
        end
    end
`else
    // No window check: upper address bits alias onto the buffer.
    assign rx_in_c  = 1'b1;
    assign tx_in_c  = 1'b1;
    assign oor_o    = 1'b0;
    assign unused_c = ^{wbrx_adr_i[31:AW+2], wbrx_adr_i[1:0], wbtx_adr_i[31:AW+2],
                        wbtx_adr_i[1:0], wbrx_cti_i, wbtx_cti_i, BASE_ADR, oor_clr_i};
`endif

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant strobes; ties go to the port not served last.
    always_comb begin
        state_nxt  = state;
        start_rx_c = 1'b0;
        start_tx_c = 1'b0;
        case (state)
            IDLE: begin
                if (rx_req_c && (!tx_req_c || last_tx)) begin
                    state_nxt  = GRANT_RX;
                    start_rx_c = 1'b1;
                end else if (tx_req_c) begin
                    state_nxt  = GRANT_TX;
                    start_tx_c = 1'b1;
                end
            end
            GRANT_RX: state_nxt = IDLE;
            GRANT_TX: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // RAM write on the grant edge; contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && start_rx_c && rx_in_c) begin
            mem[rx_idx_c] <= wbrx_dat_i;
        end
    end

    // Terminations, read data and round-robin history.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wbrx_ack_o <= 1'b0;
            wbrx_err_o <= 1'b0;
            wbtx_ack_o <= 1'b0;
            wbtx_err_o <= 1'b0;
            wbtx_dat_o <= 32'h0;
            last_tx    <= 1'b1;
        end else begin
            wbrx_ack_o <= start_rx_c & rx_in_c;
            wbrx_err_o <= start_rx_c & ~rx_in_c;
            wbtx_ack_o <= start_tx_c & tx_in_c;
            wbtx_err_o <= start_tx_c & ~tx_in_c;
            if (start_rx_c) begin
                last_tx <= 1'b0;
            end
            if (start_tx_c) begin
                last_tx    <= 1'b1;
                wbtx_dat_o <= tx_in_c ? mem[tx_idx_c] : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_minimac_bufmem.sv
// Directed bench for minimac_bufmem: vector table plus hand-written corner cases.
module tb_minimac_bufmem;

`ifdef MINIMAC_BUFMEM_OOR_ERR_EN
    localparam logic [31:0] WIN = 32'h4000_0000;
`else
    localparam logic [31:0] WIN = 32'h0000_0000;
`endif
    localparam int unsigned AW = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rx_adr = '0;
    logic [2:0]  rx_cti = '0;
    logic        rx_cyc = 1'b0;
    logic        rx_stb = 1'b0;
    logic [31:0] rx_dat = '0;
    logic        rx_ack;
    logic        rx_err;
    logic [31:0] tx_adr = '0;
    logic [2:0]  tx_cti = '0;
    logic        tx_cyc = 1'b0;
    logic        tx_stb = 1'b0;
    logic        tx_ack;
    logic        tx_err;
    logic [31:0] tx_dat;
    logic        oor;
    logic        oor_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int rx_terms = 0;
    int tx_terms = 0;
    int viol = 0;
    bit prev_rx = 1'b0;
    bit prev_tx = 1'b0;

    minimac_bufmem #(.BASE_ADR(WIN), .AW(AW)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .wbrx_adr_i(rx_adr), .wbrx_cti_i(rx_cti), .wbrx_cyc_i(rx_cyc),
        .wbrx_stb_i(rx_stb), .wbrx_dat_i(rx_dat),
        .wbrx_ack_o(rx_ack), .wbrx_err_o(rx_err),
        .wbtx_adr_i(tx_adr), .wbtx_cti_i(tx_cti), .wbtx_cyc_i(tx_cyc),
        .wbtx_stb_i(tx_stb),
        .wbtx_ack_o(tx_ack), .wbtx_err_o(tx_err), .wbtx_dat_o(tx_dat),
        .oor_o(oor), .oor_clr_i(oor_clr)
    );

    always #5 clk = ~clk;

    // Termination monitor: counts pulses and flags illegal overlaps or stretched pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_ack | rx_err) rx_terms++;
            if (tx_ack | tx_err) tx_terms++;
            if ((rx_ack & rx_err) | (tx_ack & tx_err) | ((rx_ack | rx_err) & (tx_ack | tx_err)))
                viol++;
            if (((rx_ack | rx_err) && prev_rx) || ((tx_ack | tx_err) && prev_tx))
                viol++;
            prev_rx = rx_ack | rx_err;
            prev_tx = tx_ack | tx_err;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access with stb held until the termination; inputs change on negedges.
    task automatic acc(input bit is_tx, input logic [31:0] adr, input logic [31:0] dat,
                       output bit ack, output bit err, output logic [31:0] rdat);
        ack = 1'b0; err = 1'b0; rdat = '0;
        if (is_tx) begin
            tx_adr = adr; tx_cyc = 1'b1; tx_stb = 1'b1;
        end else begin
            rx_adr = adr; rx_dat = dat; rx_cyc = 1'b1; rx_stb = 1'b1;
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (is_tx ? (tx_ack | tx_err) : (rx_ack | rx_err)) begin
                ack  = is_tx ? tx_ack : rx_ack;
                err  = is_tx ? tx_err : rx_err;
                rdat = tx_dat;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        rx_cyc = 1'b0; rx_stb = 1'b0; tx_cyc = 1'b0; tx_stb = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        idle(0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          is_tx;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    bit          a, e;
    logic [31:0] d;
    int          rx0, tx0;

    initial begin
        vecs.push_back('{1'b0, WIN | 32'h10,   32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b1, WIN | 32'h10,   32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b0, WIN | 32'h14,   32'h0BADF00D, 32'h0});
        vecs.push_back('{1'b0, WIN | 32'h18,   32'hA5A5A5A5, 32'h0});
        vecs.push_back('{1'b1, WIN | 32'h14,   32'h0,        32'h0BADF00D});
        vecs.push_back('{1'b1, WIN | 32'h18,   32'h0,        32'hA5A5A5A5});
        vecs.push_back('{1'b0, WIN | 32'h1FFC, 32'h7E57_0001, 32'h0});
        vecs.push_back('{1'b1, WIN | 32'h1FFC, 32'h0,        32'h7E57_0001});
        vecs.push_back('{1'b0, WIN | 32'h10,   32'h11111111, 32'h0});
        vecs.push_back('{1'b1, WIN | 32'h10,   32'h0,        32'h11111111});
`ifndef MINIMAC_BUFMEM_OOR_ERR_EN
        vecs.push_back('{1'b0, 32'h0000_2004,  32'h1234_5678, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0004,  32'h0,        32'h1234_5678});
`endif

        do_reset();
        chk("reset_rx_ack", 32'(rx_ack), 32'h0);
        chk("reset_rx_err", 32'(rx_err), 32'h0);
        chk("reset_tx_ack", 32'(tx_ack), 32'h0);
        chk("reset_tx_dat", tx_dat, 32'h0);
        chk("reset_oor", 32'(oor), 32'h0);

        // Table: each RX vector is followed directly by the next grant.
        foreach (vecs[i]) begin
            acc(vecs[i].is_tx, vecs[i].adr, vecs[i].dat, a, e, d);
            chk($sformatf("vec%0d_ack", i), 32'(a), 32'h1);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'h0);
            if (vecs[i].is_tx) chk($sformatf("vec%0d_dat", i), d, vecs[i].exp);
            if (i + 1 < vecs.size() && vecs[i+1].is_tx == vecs[i].is_tx) idle(0);
            else if (vecs[i].is_tx) idle(0);
        end
        idle(2);

        // Simultaneous requests after reset: RX first, TX two cycles later.
        do_reset();
        rx_adr = WIN | 32'h40; rx_dat = 32'h5555_AAAA; rx_cyc = 1'b1; rx_stb = 1'b1;
        tx_adr = WIN | 32'h10; tx_cyc = 1'b1; tx_stb = 1'b1;
        @(negedge clk);
        chk("rr1_rx_ack", 32'(rx_ack), 32'h1);
        chk("rr1_tx_ack_early", 32'(tx_ack), 32'h0);
        rx_cyc = 1'b0; rx_stb = 1'b0;
        @(negedge clk);
        chk("rr1_gap", 32'({rx_ack, tx_ack}), 32'h0);
        @(negedge clk);
        chk("rr1_tx_ack", 32'(tx_ack), 32'h1);
        chk("rr1_tx_dat", tx_dat, 32'h11111111);
        idle(0);
        acc(1'b0, WIN | 32'h44, 32'h4444_4444, a, e, d);
        idle(1);
        // RX was served last, so the next tie goes to TX.
        tx_adr = WIN | 32'h40; tx_cyc = 1'b1; tx_stb = 1'b1;
        rx_adr = WIN | 32'h48; rx_dat = 32'h4848_4848; rx_cyc = 1'b1; rx_stb = 1'b1;
        @(negedge clk);
        chk("rr2_tx_ack", 32'(tx_ack), 32'h1);
        chk("rr2_rx_ack_early", 32'(rx_ack), 32'h0);
        chk("rr2_tx_dat", tx_dat, 32'h5555_AAAA);
        tx_cyc = 1'b0; tx_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rr2_rx_ack", 32'(rx_ack), 32'h1);
        idle(2);

        // Reset during GRANT_TX.
        tx_adr = WIN | 32'h10; tx_cyc = 1'b1; tx_stb = 1'b1;
        @(negedge clk);
        chk("rst_grant_ack", 32'(tx_ack), 32'h1);
        chk("rst_grant_dat", tx_dat, 32'h11111111);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_after_ack", 32'(tx_ack), 32'h0);
        chk("rst_after_dat", tx_dat, 32'h0);
        rst = 1'b0;
        idle(1);
        acc(1'b1, WIN | 32'h10, 32'h0, a, e, d);
        chk("rst_ram_kept", d, 32'h11111111);
        idle(1);

`ifdef MINIMAC_BUFMEM_OOR_ERR_EN
        // Out-of-window accesses.
        acc(1'b0, 32'h0000_0010, 32'hBAD0BAD0, a, e, d);
        chk("oor_rx_err", 32'(e), 32'h1);
        chk("oor_rx_ack", 32'(a), 32'h0);
        chk("oor_flag", 32'(oor), 32'h1);
        idle(1);
        acc(1'b1, WIN | 32'h10, 32'h0, a, e, d);
        chk("oor_ram_unchanged", d, 32'h11111111);
        idle(0);
        acc(1'b1, 32'h0000_0010, 32'h0, a, e, d);
        chk("oor_tx_err", 32'(e), 32'h1);
        chk("oor_tx_dat", d, 32'h0);
        idle(1);
        oor_clr = 1'b1;
        @(negedge clk);
        oor_clr = 1'b0;
        chk("oor_cleared", 32'(oor), 32'h0);
        idle(1);
`endif

        // Full-depth write then read, address as data.
        rx0 = rx_terms;
        tx0 = tx_terms;
        for (int i = 0; i < (1 << AW); i++) begin
            acc(1'b0, WIN | 32'(i << 2), WIN | 32'(i << 2), a, e, d);
            if (!a) chk($sformatf("fill%0d_ack", i), 32'(a), 32'h1);
        end
        idle(3);
        for (int i = 0; i < (1 << AW); i++) begin
            acc(1'b1, WIN | 32'(i << 2), 32'h0, a, e, d);
            chk($sformatf("dump%0d", i), d, WIN | 32'(i << 2));
        end
        idle(4);
        chk("fill_ack_count", 32'(rx_terms - rx0), 32'(1 << AW));
        chk("dump_ack_count", 32'(tx_terms - tx0), 32'(1 << AW));
        chk("term_violations", 32'(viol), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
